// File: rtl/regfile_flags.sv
// 2**AW x WIDTH register file with two combinational read ports and Z/V flag registers.
// Define REGFILE_BYPASS_EN to forward write data onto a read port addressing the register being written.

module regfile_flags_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)  q <= '0;
    else if (en) q <= d;
endmodule

module regfile_flags #(
  parameter int WIDTH = 32,
  parameter int AW    = 5
) (
  input  logic             Clk,
  input  logic             Clrn,
  input  logic [AW-1:0]    Ra,
  input  logic [AW-1:0]    Rb,
  output logic [WIDTH-1:0] Qa,
  output logic [WIDTH-1:0] Qb,
  input  logic             We,
  input  logic [AW-1:0]    Wr,
  input  logic [WIDTH-1:0] D,
  input  logic             Fwe,
  input  logic             Zin,
  input  logic             Vin,
  output logic             Zf,
  output logic             Vf
);
  localparam int NREG = 1 << AW;

  logic [NREG-1:0][WIDTH-1:0] regs;

  // r0 has no storage; it is hardwired to zero so writes to it vanish
  assign regs[0] = '0;

  for (genvar g = 1; g < NREG; g++) begin : g_reg
    regfile_flags_reg #(.WIDTH(WIDTH)) u_reg (
      .clk   (Clk),
      .rst_n (Clrn),
      .en    (We && (Wr == AW'(g))),
      .d     (D),
      .q     (regs[g])
    );
  end

`ifdef REGFILE_BYPASS_EN
  logic wr_live;
  assign wr_live = We && (Wr != '0);

  always_comb begin
    Qa = regs[Ra];
    Qb = regs[Rb];
    if (wr_live && (Ra == Wr)) Qa = D;
    if (wr_live && (Rb == Wr)) Qb = D;
  end
`else
  assign Qa = regs[Ra];
  assign Qb = regs[Rb];
`endif

  always_ff @(posedge Clk or negedge Clrn)
    if (!Clrn) begin
      Zf <= 1'b0;
      Vf <= 1'b0;
    end else if (Fwe) begin
      Zf <= Zin;
      Vf <= Vin;
    end
endmodule

// File: tb/tb_regfile_flags.sv
// Self-checking bench for regfile_flags: vector table through a scoreboard plus reset/bypass sequences.

module tb_regfile_flags;
  logic        Clk = 1'b0;
  logic        Clrn;
  logic [4:0]  Ra, Rb, Wr;
  logic [31:0] Qa, Qb, D;
  logic        We, Fwe, Zin, Vin, Zf, Vf;

  int total = 0;
  int bad   = 0;

  regfile_flags #(.WIDTH(32), .AW(5)) dut (
    .Clk(Clk), .Clrn(Clrn), .Ra(Ra), .Rb(Rb), .Qa(Qa), .Qb(Qb),
    .We(We), .Wr(Wr), .D(D), .Fwe(Fwe), .Zin(Zin), .Vin(Vin),
    .Zf(Zf), .Vf(Vf)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        we;
    logic [4:0]  wr;
    logic [31:0] d;
    logic        fwe, zin, vin;
    logic [4:0]  ra, rb;
    logic [31:0] qa, qb;
    logic        zf, vf;
  } vec_t;

  typedef struct {
    logic [31:0] qa, qb;
    logic        zf, vf;
  } exp_t;

  vec_t vecs[9];
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic idle();
    We = 1'b0; Wr = '0; D = '0; Fwe = 1'b0; Zin = 1'b0; Vin = 1'b0;
  endtask

  initial begin
    exp_t e;
    logic [31:0] r3_old;

    vecs[0] = '{1'b1, 5'd1,  32'hF0F0F0F0, 1'b0, 1'b0, 1'b0, 5'd1,  5'd0,  32'hF0F0F0F0, 32'h00000000, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 5'd2,  32'h0F0F0F0F, 1'b0, 1'b0, 1'b0, 5'd1,  5'd2,  32'hF0F0F0F0, 32'h0F0F0F0F, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 5'd0,  5'd1,  32'h00000000, 32'hF0F0F0F0, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 5'd1,  32'h12345678, 1'b0, 1'b0, 1'b0, 5'd1,  5'd1,  32'hF0F0F0F0, 32'hF0F0F0F0, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 5'd0,  32'h00000000, 1'b1, 1'b1, 1'b0, 5'd2,  5'd0,  32'h0F0F0F0F, 32'h00000000, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 5'd0,  32'h00000000, 1'b0, 1'b0, 1'b1, 5'd2,  5'd0,  32'h0F0F0F0F, 32'h00000000, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 5'd31, 32'hAAAAAAAA, 1'b1, 1'b0, 1'b1, 5'd31, 5'd2,  32'hAAAAAAAA, 32'h0F0F0F0F, 1'b0, 1'b1};
    vecs[7] = '{1'b1, 5'd31, 32'h55555555, 1'b0, 1'b1, 1'b0, 5'd31, 5'd31, 32'h55555555, 32'h55555555, 1'b0, 1'b1};
    vecs[8] = '{1'b1, 5'd5,  32'h00000001, 1'b1, 1'b1, 1'b1, 5'd5,  5'd31, 32'h00000001, 32'h55555555, 1'b1, 1'b1};

    Clrn = 1'b0; Ra = 5'd7; Rb = 5'd31;
    idle();
    #2;
    chk("reset_qa", Qa, 32'h0);
    chk("reset_qb", Qb, 32'h0);
    chk("reset_zf", {31'h0, Zf}, 32'h0);
    chk("reset_vf", {31'h0, Vf}, 32'h0);

    // release reset with a write pending: the first edge must take it
    @(negedge Clk);
    Clrn = 1'b1; We = 1'b1; Wr = 5'd7; D = 32'hCAFEF00D; Ra = 5'd7;
    @(posedge Clk); #1;
    chk("first_write_after_reset", Qa, 32'hCAFEF00D);

    for (int i = 0; i < 9; i++) begin
      @(negedge Clk);
      We = vecs[i].we; Wr = vecs[i].wr; D = vecs[i].d;
      Fwe = vecs[i].fwe; Zin = vecs[i].zin; Vin = vecs[i].vin;
      Ra = vecs[i].ra; Rb = vecs[i].rb;
      sb.push_back('{vecs[i].qa, vecs[i].qb, vecs[i].zf, vecs[i].vf});
      @(posedge Clk); #1;
      if (sb.size() == 0) begin
        bad++; total++;
        $display("FAIL scoreboard_empty vec=%0d", i);
      end else begin
        e = sb.pop_front();
        chk($sformatf("vec%0d_qa", i), Qa, e.qa);
        chk($sformatf("vec%0d_qb", i), Qb, e.qb);
        chk($sformatf("vec%0d_zf", i), {31'h0, Zf}, {31'h0, e.zf});
        chk($sformatf("vec%0d_vf", i), {31'h0, Vf}, {31'h0, e.vf});
      end
    end

    // same-cycle read of the register being written
    @(negedge Clk);
    We = 1'b1; Wr = 5'd3; D = 32'hDEADBEEF; Fwe = 1'b0; Ra = 5'd0; Rb = 5'd0;
    @(negedge Clk);
    r3_old = 32'hDEADBEEF;
    We = 1'b1; Wr = 5'd3; D = 32'h12345678; Ra = 5'd3; Rb = 5'd3;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("bypass_qa", Qa, 32'h12345678);
    chk("bypass_qb", Qb, 32'h12345678);
`else
    chk("nobypass_qa", Qa, r3_old);
    chk("nobypass_qb", Qb, r3_old);
`endif
    @(posedge Clk); #1;
    idle();
    chk("r3_after_edge_qa", Qa, 32'h12345678);
    chk("r3_after_edge_qb", Qb, 32'h12345678);

    // write to r0 never reaches a read port, even in the write cycle
    @(negedge Clk);
    We = 1'b1; Wr = 5'd0; D = 32'hFFFFFFFF; Ra = 5'd0; Rb = 5'd0;
    #1;
    chk("r0_write_cycle", Qa, 32'h0);
    @(posedge Clk); #1;
    idle();
    chk("r0_after_write", Qa, 32'h0);

    // mid-cycle async reset clears everything without a clock edge
    @(negedge Clk);
    #2;
    Clrn = 1'b0;
    #1;
    for (int a = 0; a < 32; a++) begin
      Ra = 5'(a); Rb = 5'(31 - a);
      #0.1;
      chk($sformatf("async_clr_qa_r%0d", a), Qa, 32'h0);
      chk($sformatf("async_clr_qb_r%0d", 31 - a), Qb, 32'h0);
    end
    chk("async_clr_zf", {31'h0, Zf}, 32'h0);
    chk("async_clr_vf", {31'h0, Vf}, 32'h0);

    // write during reset is dropped
    @(negedge Clk);
    Clrn = 1'b1;
    We = 1'b1; Wr = 5'd31; D = 32'h11111111;
    @(posedge Clk); #1;
    @(negedge Clk);
    Clrn = 1'b0; We = 1'b1; Wr = 5'd31; D = 32'hAAAAAAAA; Fwe = 1'b1; Zin = 1'b1; Vin = 1'b1;
    @(posedge Clk); #1;
    @(negedge Clk);
    Clrn = 1'b1; idle(); Ra = 5'd31; Rb = 5'd31;
    #1;
    chk("write_in_reset_r31", Qa, 32'h0);
    chk("flags_in_reset_zf", {31'h0, Zf}, 32'h0);
    @(posedge Clk); #1;
    chk("r31_stays_zero", Qb, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
